// File: rtl/sparse_fc_pkg.sv
// Shared types for the sparse ternary FC neuron: weight codes, FSM states
// and the saturating accumulate step used by the datapath.
package sparse_fc_pkg;

    localparam logic [1:0] WT_ZERO = 2'b00;
    localparam logic [1:0] WT_POS  = 2'b01;
    localparam logic [1:0] WT_RSVD = 2'b10;
    localparam logic [1:0] WT_NEG  = 2'b11;

    // Working width for the saturating add; accumulators up to 31 bits fit.
    localparam int SAT_W = 32;

    typedef enum logic [1:0] {
        LOAD,
        ACCUM,
        DONE
    } state_t;

    typedef struct packed {
        logic                    sat;
        logic signed [SAT_W-1:0] val;
    } sat_res_t;

    // Adds two sign-extended operands and clamps the result to a w-bit
    // signed range; sat reports whether the clamp was applied.
    function automatic sat_res_t sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      w
    );
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_res_t                r;
        sum = a + b;
        hi  = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
        lo  = ~hi;
        r.sat = 1'b0;
        r.val = sum;
        if (sum > hi) begin
            r.sat = 1'b1;
            r.val = hi;
        end else if (sum < lo) begin
            r.sat = 1'b1;
            r.val = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/sparse_pack_buf.sv
// Packed buffer of non-zero {activation, sign} pairs for one input vector.
// Ports: clk/reset, clear (end of vector), push/push_data (write at wr_ptr),
// rd_ptr/rd_data (async read), wr_ptr (entries held so far).
module sparse_pack_buf #(
    parameter int N     = 128,
    parameter int ACT_W = 9,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [ACT_W:0]   push_data,
    input  logic [CNT_W-1:0] rd_ptr,
    output logic [ACT_W:0]   rd_data,
    output logic [CNT_W-1:0] wr_ptr
);

    localparam int AW = (N > 1) ? $clog2(N) : 1;

    logic [ACT_W:0] mem [N];
    logic           unused_rd;

    // Counters reach N, so only the low bits address the array.
    assign unused_rd = ^rd_ptr;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sparse_ternary_fc.sv
// Sparse ternary-weight FC neuron: packs non-zero products during LOAD,
// sums them with per-step saturation in ACCUM, presents the result in DONE.
// Ports: in_valid/in_ready/in_act/in_wt beat input; out_valid/out_ready
// result handshake with out_data, out_nnz, out_sat and out_err.
module sparse_ternary_fc
    import sparse_fc_pkg::*;
#(
    parameter int N     = 128,
    parameter int ACT_W = 9,
    parameter int ACC_W = 16,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [ACT_W-1:0] in_act,
    input  logic [1:0]              in_wt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0]        out_nnz,
    output logic                    out_sat,
    output logic                    out_err
);

    state_t                  state;
    state_t                  state_nxt;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        beat_cnt;
    logic [CNT_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        wr_ptr;
    logic                    sat_flag;
    logic                    err_flag;
    logic                    accept;
    logic                    nz_wt;
    logic                    push;
    logic                    last_beat;
    logic                    out_fire;
    logic [ACT_W:0]          rd_data;
    logic signed [ACT_W-1:0] rd_act;
    logic signed [SAT_W-1:0] term;
    sat_res_t                step;
    logic                    unused_step;

    assign accept    = in_valid && in_ready;
    assign nz_wt     = (in_wt == WT_POS) || (in_wt == WT_NEG);
    assign push      = accept && nz_wt && (in_act != '0);
    assign last_beat = accept && (beat_cnt == CNT_W'(N - 1));
    assign out_fire  = out_valid && out_ready;

    sparse_pack_buf #(
        .N     (N),
        .ACT_W (ACT_W),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .clear     (out_fire),
        .push      (push),
        .push_data ({in_act, in_wt == WT_NEG}),
        .rd_ptr    (rd_ptr),
        .rd_data   (rd_data),
        .wr_ptr    (wr_ptr)
    );

    // Entry layout is {act, sign}; sign set means the weight was -1.
    assign rd_act = rd_data[ACT_W:1];
    assign term   = rd_data[0] ? -SAT_W'(rd_act) : SAT_W'(rd_act);
    assign step   = sat_add(SAT_W'(acc), term, ACC_W);

    // Only the low ACC_W bits of the clamped value are meaningful.
    assign unused_step = ^step;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            LOAD: begin
                if (last_beat) begin
                    // Nothing packed at all: skip ACCUM entirely.
                    if ((wr_ptr == '0) && !push) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (rd_ptr == wr_ptr - CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_nnz   = '0;
        out_sat   = 1'b0;
        out_err   = 1'b0;
        unique case (state)
            LOAD: in_ready = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                out_data  = acc;
                out_nnz   = wr_ptr;
                out_sat   = sat_flag;
                out_err   = err_flag;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || out_fire) begin
            acc      <= '0;
            beat_cnt <= '0;
            rd_ptr   <= '0;
            sat_flag <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            if (accept) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
                if (in_wt == WT_RSVD) begin
                    err_flag <= 1'b1;
                end
            end
            if (state == ACCUM) begin
                acc    <= step.val[ACC_W-1:0];
                rd_ptr <= rd_ptr + CNT_W'(1);
                if (step.sat) begin
                    sat_flag <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sparse_ternary_fc.sv
// Directed bench for sparse_ternary_fc: an N=8/ACC_W=10 instance for the
// main scenarios and an N=4/ACC_W=16 instance for the all-zero vector.
module tb_sparse_ternary_fc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic              a_in_valid;
    logic              a_in_ready;
    logic signed [8:0] a_in_act;
    logic [1:0]        a_in_wt;
    logic              a_out_valid;
    logic              a_out_ready;
    logic signed [9:0] a_out_data;
    logic [3:0]        a_out_nnz;
    logic              a_out_sat;
    logic              a_out_err;

    logic               b_in_valid;
    logic               b_in_ready;
    logic signed [8:0]  b_in_act;
    logic [1:0]         b_in_wt;
    logic               b_out_valid;
    logic               b_out_ready;
    logic signed [15:0] b_out_data;
    logic [2:0]         b_out_nnz;
    logic               b_out_sat;
    logic               b_out_err;

    int vectors     = 0;
    int miscompares = 0;

    logic signed [8:0] vec_act [8];
    logic [1:0]        vec_wt  [8];

    sparse_ternary_fc #(
        .N     (8),
        .ACT_W (9),
        .ACC_W (10)
    ) u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_act    (a_in_act),
        .in_wt     (a_in_wt),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_nnz   (a_out_nnz),
        .out_sat   (a_out_sat),
        .out_err   (a_out_err)
    );

    sparse_ternary_fc #(
        .N     (4),
        .ACT_W (9),
        .ACC_W (16)
    ) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_act    (b_in_act),
        .in_wt     (b_in_wt),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_nnz   (b_out_nnz),
        .out_sat   (b_out_sat),
        .out_err   (b_out_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input int max_gap, input int beats);
        int w;
        for (int i = 0; i < beats; i++) begin
            a_in_valid = 1'b0;
            if (max_gap > 0) begin
                repeat ($urandom_range(max_gap, 0)) tick();
            end
            a_in_act   = vec_act[i];
            a_in_wt    = vec_wt[i];
            a_in_valid = 1'b1;
            w = 0;
            while (!a_in_ready && w < 50) begin
                tick();
                w++;
            end
            tick();
        end
        a_in_valid = 1'b0;
    endtask

    task automatic wait_a(output int cyc);
        cyc = 0;
        while (!a_out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic consume_a();
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
    endtask

    task automatic fill(input int base, input logic [1:0] wt);
        for (int i = 0; i < 8; i++) begin
            vec_act[i] = 9'(base + i);
            vec_wt[i]  = wt;
        end
    endtask

    task automatic load_sparse();
        vec_act = '{9'sd5, 9'sd0, 9'sd3, -9'sd4, 9'sd7, 9'sd0, 9'sd2, 9'sd9};
        vec_wt  = '{2'b01, 2'b01, 2'b00, 2'b11, 2'b11, 2'b00, 2'b01, 2'b00};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++;
        if (a_in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready got %b want 1", a_in_ready);
            miscompares++;
        end
        vectors++;
        if (a_out_valid !== 1'b0) begin
            $display("FAIL reset_out_valid got %b want 0", a_out_valid);
            miscompares++;
        end
        vectors++;
        if (a_out_data !== 10'sd0) begin
            $display("FAIL reset_out_data got %0d want 0", a_out_data);
            miscompares++;
        end
        vectors++;
        if (a_out_nnz !== 4'd0) begin
            $display("FAIL reset_out_nnz got %0d want 0", a_out_nnz);
            miscompares++;
        end
        vectors++;
        if ({a_out_sat, a_out_err} !== 2'b00) begin
            $display("FAIL reset_flags got %b want 00", {a_out_sat, a_out_err});
            miscompares++;
        end
        vectors++;
        if ({b_in_ready, b_out_valid} !== 2'b10) begin
            $display("FAIL reset_b got %b want 10", {b_in_ready, b_out_valid});
            miscompares++;
        end
    endtask

    task automatic test_dense();
        int cyc;
        fill(1, 2'b01);
        send_a(0, 8);
        wait_a(cyc);
        vectors++;
        if (cyc !== 8) begin
            $display("FAIL dense_latency got %0d want 8", cyc);
            miscompares++;
        end
        vectors++;
        if (a_out_data !== 10'sd36) begin
            $display("FAIL dense_data got %0d want 36", a_out_data);
            miscompares++;
        end
        vectors++;
        if (a_out_nnz !== 4'd8) begin
            $display("FAIL dense_nnz got %0d want 8", a_out_nnz);
            miscompares++;
        end
        vectors++;
        if ({a_out_sat, a_out_err} !== 2'b00) begin
            $display("FAIL dense_flags got %b want 00", {a_out_sat, a_out_err});
            miscompares++;
        end
        consume_a();
        vectors++;
        if ({a_out_valid, a_in_ready} !== 2'b01) begin
            $display("FAIL dense_release got %b want 01", {a_out_valid, a_in_ready});
            miscompares++;
        end
    endtask

    task automatic test_sparse();
        int cyc;
        load_sparse();
        send_a(0, 8);
        wait_a(cyc);
        vectors++;
        if (cyc !== 4) begin
            $display("FAIL sparse_latency got %0d want 4", cyc);
            miscompares++;
        end
        vectors++;
        if (a_out_data !== 10'sd4) begin
            $display("FAIL sparse_data got %0d want 4", a_out_data);
            miscompares++;
        end
        vectors++;
        if (a_out_nnz !== 4'd4) begin
            $display("FAIL sparse_nnz got %0d want 4", a_out_nnz);
            miscompares++;
        end
        consume_a();
    endtask

    task automatic test_all_zero();
        for (int i = 0; i < 4; i++) begin
            b_in_act   = 9'(i + 1);
            b_in_wt    = 2'b00;
            b_in_valid = 1'b1;
            tick();
        end
        b_in_valid = 1'b0;
        vectors++;
        if ({b_out_valid, b_in_ready} !== 2'b10) begin
            $display("FAIL zero_done got %b want 10", {b_out_valid, b_in_ready});
            miscompares++;
        end
        vectors++;
        if (b_out_data !== 16'sd0) begin
            $display("FAIL zero_data got %0d want 0", b_out_data);
            miscompares++;
        end
        vectors++;
        if (b_out_nnz !== 3'd0) begin
            $display("FAIL zero_nnz got %0d want 0", b_out_nnz);
            miscompares++;
        end
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        vectors++;
        if ({b_out_valid, b_in_ready} !== 2'b01) begin
            $display("FAIL zero_release got %b want 01", {b_out_valid, b_in_ready});
            miscompares++;
        end
    endtask

    task automatic test_saturation();
        int cyc;
        fill(255, 2'b01);
        for (int i = 0; i < 8; i++) vec_act[i] = 9'sd255;
        send_a(0, 8);
        wait_a(cyc);
        vectors++;
        if (a_out_data !== 10'sd511) begin
            $display("FAIL sat_pos_data got %0d want 511", a_out_data);
            miscompares++;
        end
        vectors++;
        if ({a_out_sat, a_out_err, a_out_nnz} !== {2'b10, 4'd8}) begin
            $display("FAIL sat_pos_flags got %b/%b/%0d want 1/0/8",
                     a_out_sat, a_out_err, a_out_nnz);
            miscompares++;
        end
        consume_a();
        for (int i = 0; i < 8; i++) vec_act[i] = -9'sd256;
        send_a(0, 8);
        wait_a(cyc);
        vectors++;
        if (a_out_data !== -10'sd512) begin
            $display("FAIL sat_neg_data got %0d want -512", a_out_data);
            miscompares++;
        end
        vectors++;
        if (a_out_sat !== 1'b1) begin
            $display("FAIL sat_neg_flag got %b want 1", a_out_sat);
            miscompares++;
        end
        consume_a();
    endtask

    task automatic test_reserved();
        int cyc;
        fill(1, 2'b01);
        vec_wt[3] = 2'b10;
        send_a(0, 8);
        wait_a(cyc);
        vectors++;
        if (a_out_data !== 10'sd32) begin
            $display("FAIL rsvd_data got %0d want 32", a_out_data);
            miscompares++;
        end
        vectors++;
        if (a_out_nnz !== 4'd7) begin
            $display("FAIL rsvd_nnz got %0d want 7", a_out_nnz);
            miscompares++;
        end
        vectors++;
        if ({a_out_err, a_out_sat} !== 2'b10) begin
            $display("FAIL rsvd_flags got %b want 10", {a_out_err, a_out_sat});
            miscompares++;
        end
        consume_a();
        fill(1, 2'b01);
        send_a(0, 8);
        wait_a(cyc);
        vectors++;
        if (a_out_err !== 1'b0) begin
            $display("FAIL rsvd_cleared got %b want 0", a_out_err);
            miscompares++;
        end
        consume_a();
    endtask

    task automatic test_back_to_back();
        int cyc;
        fill(1, 2'b01);
        send_a(0, 8);
        wait_a(cyc);
        for (int c = 0; c < 5; c++) begin
            a_in_valid = 1'b1;
            a_in_act   = 9'sd100;
            a_in_wt    = 2'b01;
            vectors++;
            if ({a_out_valid, a_in_ready} !== 2'b10 ||
                a_out_data !== 10'sd36 || a_out_nnz !== 4'd8) begin
                $display("FAIL hold_c%0d got v%b r%b d%0d n%0d want v1 r0 d36 n8",
                         c, a_out_valid, a_in_ready, a_out_data, a_out_nnz);
                miscompares++;
            end
            tick();
        end
        a_in_valid = 1'b0;
        consume_a();
        load_sparse();
        send_a(3, 8);
        wait_a(cyc);
        vectors++;
        if (a_out_data !== 10'sd4 || a_out_nnz !== 4'd4) begin
            $display("FAIL gap_sparse got %0d/%0d want 4/4", a_out_data, a_out_nnz);
            miscompares++;
        end
        consume_a();
        fill(1, 2'b01);
        send_a(2, 8);
        wait_a(cyc);
        vectors++;
        if (a_out_data !== 10'sd36 || a_out_nnz !== 4'd8) begin
            $display("FAIL gap_dense got %0d/%0d want 36/8", a_out_data, a_out_nnz);
            miscompares++;
        end
        consume_a();
    endtask

    task automatic test_reset_mid();
        int cyc;
        fill(1, 2'b01);
        send_a(0, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({a_in_ready, a_out_valid, a_out_nnz} !== {2'b10, 4'd0} ||
            a_out_data !== 10'sd0) begin
            $display("FAIL rst_load got r%b v%b n%0d d%0d want r1 v0 n0 d0",
                     a_in_ready, a_out_valid, a_out_nnz, a_out_data);
            miscompares++;
        end
        load_sparse();
        send_a(0, 8);
        wait_a(cyc);
        vectors++;
        if (cyc !== 4 || a_out_data !== 10'sd4 || a_out_nnz !== 4'd4) begin
            $display("FAIL rst_load_next got c%0d d%0d n%0d want c4 d4 n4",
                     cyc, a_out_data, a_out_nnz);
            miscompares++;
        end
        consume_a();
        fill(1, 2'b01);
        send_a(0, 8);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({a_in_ready, a_out_valid, a_out_sat, a_out_err} !== 4'b1000 ||
            a_out_data !== 10'sd0) begin
            $display("FAIL rst_accum got r%b v%b d%0d want r1 v0 d0",
                     a_in_ready, a_out_valid, a_out_data);
            miscompares++;
        end
        send_a(0, 8);
        wait_a(cyc);
        vectors++;
        if (cyc !== 8 || a_out_data !== 10'sd36 || a_out_nnz !== 4'd8) begin
            $display("FAIL rst_accum_next got c%0d d%0d n%0d want c8 d36 n8",
                     cyc, a_out_data, a_out_nnz);
            miscompares++;
        end
        consume_a();
    endtask

    initial begin
        reset       = 1'b1;
        a_in_valid  = 1'b0;
        a_in_act    = '0;
        a_in_wt     = 2'b00;
        a_out_ready = 1'b0;
        b_in_valid  = 1'b0;
        b_in_act    = '0;
        b_in_wt     = 2'b00;
        b_out_ready = 1'b0;
        test_reset();
        test_dense();
        test_sparse();
        test_all_zero();
        test_saturation();
        test_reserved();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
